// File: rtl/bnn_pkg.sv
// bnn_pkg: phase encodings, image geometry and layer sizes shared by the BNN blocks
package bnn_pkg;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_LAYER_1 = 3'd2;
  localparam logic [2:0] S_LAYER_2 = 3'd3;
  localparam logic [2:0] S_LAYER_3 = 3'd4;
  localparam logic [2:0] S_RESULT  = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;
  localparam int N_PIXELS = 784;
  localparam int TIMEOUT  = 1023;
  localparam int WD_W     = 10;
  localparam int L1_OUT   = 256;
  localparam int L2_OUT   = 128;
  localparam int L3_OUT   = 10;
  localparam logic [9:0] LAST_PIX = 10'(N_PIXELS - 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);
  function automatic logic is_layer(input logic [2:0] s);
    return s == S_LAYER_1 || s == S_LAYER_2 || s == S_LAYER_3;
  endfunction
  function automatic logic is_busy(input logic [2:0] s);
    return s == S_LOAD || is_layer(s);
  endfunction
endpackage

// File: rtl/bnn_sequencer_if.sv
// bnn_sequencer_if: pixel stream, image-buffer write port and layer phase bus
interface bnn_sequencer_if;
  logic pix_valid;
  logic pix_data;
  logic pix_ready;
  logic buf_wr_en;
  logic [9:0] buf_addr;
  logic buf_wr_data;
  logic [2:0] state;
  logic [2:0] layer_rst_n;
  logic l1_done;
  logic l2_done;
  logic l3_done;
  logic [3:0] class_in;
  modport master (
    input  pix_valid, pix_data, l1_done, l2_done, l3_done, class_in,
    output pix_ready, buf_wr_en, buf_addr, buf_wr_data, state, layer_rst_n
  );
  modport slave (
    output pix_valid, pix_data, l1_done, l2_done, l3_done, class_in,
    input  pix_ready, buf_wr_en, buf_addr, buf_wr_data, state, layer_rst_n
  );
endinterface

// File: rtl/bnn_watchdog.sv
// bnn_watchdog: loadable down-counter; expired once an armed count reaches zero
module bnn_watchdog #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);
  logic [W-1:0] cnt;
  logic armed;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= load_val;
      armed <= 1'b1;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end
  assign expired = armed && cnt == '0;
endmodule

// File: rtl/bnn_sequencer.sv
// bnn_sequencer: loads an image, then steps the layer phases with per-phase watchdog
module bnn_sequencer
  import bnn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  bnn_sequencer_if.master      bus,
  output logic [3:0]           class_out,
  output logic                 result_valid,
  output logic                 busy,
  output logic                 error,
  output logic [15:0]          perf_cycles
);
  logic [2:0] st, nxt;
  logic [9:0] cnt;
  logic first, accept, in_layer, load_beat, done_k, adv, entering, expired;
  assign accept    = start && (st == S_IDLE || st == S_RESULT || st == S_ERROR);
  assign in_layer  = is_layer(st);
  assign load_beat = st == S_LOAD && bus.pix_valid;
  assign done_k    = st == S_LAYER_1 ? bus.l1_done : st == S_LAYER_2 ? bus.l2_done : bus.l3_done;
  // a done seen on the first phase cycle predates the reset release and is stale
  assign adv       = in_layer && !first && done_k;
  assign entering  = is_layer(nxt) && nxt != st;
  assign bus.state = st;
  always_comb begin
    nxt = abort ? S_IDLE
        : accept ? S_LOAD
        : (load_beat && cnt == LAST_PIX) ? S_LAYER_1
        : adv ? (st == S_LAYER_3 ? S_RESULT : st + 3'd1)
        : (in_layer && expired) ? S_ERROR
        : st == 3'd7 ? S_IDLE
        : st;
  end
  bnn_watchdog #(.W(WD_W)) u_wd (
    .clk      (clk),
    .rst      (rst),
    .clear    (abort || accept),
    .load     (entering),
    .load_val (WD_LOAD),
    .en       (in_layer),
    .expired  (expired)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      st              <= S_IDLE;
      cnt             <= '0;
      first           <= 1'b0;
      bus.layer_rst_n <= 3'b000;
      bus.pix_ready   <= 1'b0;
      bus.buf_wr_en   <= 1'b0;
      bus.buf_addr    <= '0;
      bus.buf_wr_data <= 1'b0;
      class_out       <= '0;
      result_valid    <= 1'b0;
      busy            <= 1'b0;
      error           <= 1'b0;
      perf_cycles     <= '0;
    end else begin
      st              <= nxt;
      first           <= entering;
      bus.layer_rst_n <= nxt == S_LAYER_1 ? 3'b001 : nxt == S_LAYER_2 ? 3'b011 : nxt == S_LAYER_3 ? 3'b111 : 3'b000;
      bus.pix_ready   <= nxt == S_LOAD;
      busy            <= is_busy(nxt);
      bus.buf_wr_en   <= !abort && load_beat;
      if (!abort && load_beat) begin
        bus.buf_addr    <= cnt;
        bus.buf_wr_data <= bus.pix_data;
      end
      cnt          <= (abort || accept) ? '0 : load_beat ? cnt + 10'd1 : cnt;
      error        <= (abort || accept) ? 1'b0 : nxt == S_ERROR ? 1'b1 : error;
      result_valid <= (abort || accept || nxt == S_ERROR) ? 1'b0 : (st == S_LAYER_3 && nxt == S_RESULT) ? 1'b1 : result_valid;
      if (st == S_LAYER_3 && nxt == S_RESULT) class_out <= bus.class_in;
      // the accepting cycle itself counts as the first elapsed cycle
      perf_cycles  <= abort ? '0 : accept ? 16'd1 : (is_busy(st) && perf_cycles != 16'hFFFF) ? perf_cycles + 16'd1 : perf_cycles;
    end
  end
endmodule

// File: tb/tb_bnn_sequencer.sv
// tb_bnn_sequencer: directed runs with layer stubs; monitors pop queued expectations
module tb_bnn_sequencer;
  import bnn_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [3:0] class_out;
  logic result_valid, busy, error;
  logic [15:0] perf_cycles;
  bnn_sequencer_if bus();
  bnn_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .bus          (bus),
    .class_out    (class_out),
    .result_valid (result_valid),
    .busy         (busy),
    .error        (error),
    .perf_cycles  (perf_cycles)
  );
  always #5 clk = ~clk;
  typedef struct {logic [2:0] st; logic [2:0] lrn; logic bsy; int dwell;} st_exp_t;
  typedef struct {logic [3:0] cls; logic [15:0] perf;} res_exp_t;
  st_exp_t st_q[$];
  logic [10:0] wr_q[$];
  res_exp_t res_q[$];
  int n_vec = 0, n_err = 0, cyc_cnt = 0, last_chg = 0;
  logic mon_en = 1'b0, prev_rv = 1'b0;
  logic [2:0] prev_st = S_IDLE;
  int pc[3] = '{0, 0, 0};
  int lat[3] = '{196, 196, 196};
  logic stale1 = 1'b0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic push_st(input logic [2:0] s, input logic [2:0] l, input logic b, input int d);
    st_exp_t e;
    e.st = s; e.lrn = l; e.bsy = b; e.dwell = d;
    st_q.push_back(e);
  endtask
  task automatic push_res(input logic [3:0] c, input logic [15:0] p);
    res_exp_t r;
    r.cls = c; r.perf = p;
    res_q.push_back(r);
  endtask
  function automatic logic pix(input int i);
    return ((i * 13 + (i >> 4)) % 3) == 0;
  endfunction
  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask
  task automatic run_load(input logic gap);
    for (int i = 0; i < N_PIXELS; i++) begin
      bus.pix_valid = 1'b1;
      bus.pix_data  = pix(i);
      wr_q.push_back({10'(i), pix(i)});
      cyc();
      if (gap) begin
        bus.pix_valid = 1'b0;
        cyc();
      end
    end
    bus.pix_valid = 1'b0;
  endtask
  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (bus.state !== s && n < budget) begin
      cyc();
      n++;
    end
    check("wait_state", 32'(bus.state), 32'(s));
  endtask
  // layer stubs: phase counter runs while released, done after lat cycles
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    for (int k = 0; k < 3; k++) pc[k] <= bus.layer_rst_n[k] ? pc[k] + 1 : 0;
  end
  assign bus.l1_done = (bus.layer_rst_n[0] && pc[0] >= lat[0]) || stale1;
  assign bus.l2_done = bus.layer_rst_n[1] && pc[1] >= lat[1];
  assign bus.l3_done = bus.layer_rst_n[2] && pc[2] >= lat[2];
  always @(negedge clk) begin
    st_exp_t e;
    res_exp_t r;
    logic [10:0] w;
    if (mon_en) begin
      if (bus.state !== prev_st) begin
        if (st_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_state: got %0d expected no transition", bus.state);
        end else begin
          e = st_q.pop_front();
          check("state_lrn_busy_ready", {bus.state, bus.layer_rst_n, busy, bus.pix_ready}, {e.st, e.lrn, e.bsy, e.st == S_LOAD});
          if (e.dwell >= 0) check("dwell", cyc_cnt - last_chg, e.dwell);
        end
        last_chg = cyc_cnt;
        prev_st  = bus.state;
      end
      if (bus.buf_wr_en) begin
        if (wr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_write: got addr %0d expected no write", bus.buf_addr);
        end else begin
          w = wr_q.pop_front();
          check("buf_write", {bus.buf_addr, bus.buf_wr_data}, w);
        end
      end
      if (result_valid && !prev_rv) begin
        if (res_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_result: got class %0d expected none", class_out);
        end else begin
          r = res_q.pop_front();
          check("class_out", class_out, r.cls);
          check("perf_cycles", perf_cycles, r.perf);
        end
      end
      prev_rv = result_valid;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data  = 1'b0;
    bus.class_in  = 4'd0;
    repeat (3) cyc();
    check("rst_state", bus.state, S_IDLE);
    check("rst_lrn", bus.layer_rst_n, 3'b000);
    check("rst_pix_ready", bus.pix_ready, 0);
    check("rst_wr_en", bus.buf_wr_en, 0);
    check("rst_addr", bus.buf_addr, 0);
    check("rst_wr_data", bus.buf_wr_data, 0);
    check("rst_class", class_out, 0);
    check("rst_rv", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_perf", perf_cycles, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    cyc();
    // normal run, with an ignored start inside layer 3
    bus.class_in = 4'd7;
    push_st(S_LOAD, 3'b000, 1, -1);
    push_st(S_LAYER_1, 3'b001, 1, 784);
    push_st(S_LAYER_2, 3'b011, 1, 197);
    push_st(S_LAYER_3, 3'b111, 1, 197);
    push_st(S_RESULT, 3'b000, 0, 197);
    push_res(4'd7, 16'd1376);
    do_start();
    run_load(1'b0);
    wait_state(S_LAYER_3, 500);
    cyc();
    do_start();
    wait_state(S_RESULT, 400);
    check("normal_class", class_out, 7);
    check("normal_rv", result_valid, 1);
    // restart from result with a gapped load
    bus.class_in = 4'd3;
    push_st(S_LOAD, 3'b000, 1, -1);
    push_st(S_LAYER_1, 3'b001, 1, 1567);
    push_st(S_LAYER_2, 3'b011, 1, 197);
    push_st(S_LAYER_3, 3'b111, 1, 197);
    push_st(S_RESULT, 3'b000, 0, 197);
    push_res(4'd3, 16'd2159);
    do_start();
    check("restart_rv_cleared", result_valid, 0);
    run_load(1'b1);
    wait_state(S_RESULT, 1000);
    check("gapped_class", class_out, 3);
    // watchdog on layer 2
    lat[1] = 1_000_000;
    push_st(S_LOAD, 3'b000, 1, -1);
    push_st(S_LAYER_1, 3'b001, 1, 784);
    push_st(S_LAYER_2, 3'b011, 1, 197);
    push_st(S_ERROR, 3'b000, 0, 1023);
    do_start();
    run_load(1'b0);
    wait_state(S_ERROR, 1500);
    check("wd_error", error, 1);
    check("wd_lrn", bus.layer_rst_n, 3'b000);
    check("wd_rv", result_valid, 0);
    lat[1] = 196;
    // start clears error; abort with start mid layer 1
    push_st(S_LOAD, 3'b000, 1, -1);
    push_st(S_LAYER_1, 3'b001, 1, 784);
    push_st(S_IDLE, 3'b000, 0, 6);
    do_start();
    check("error_cleared", error, 0);
    run_load(1'b0);
    repeat (5) cyc();
    abort = 1'b1;
    start = 1'b1;
    cyc();
    abort = 1'b0;
    start = 1'b0;
    check("abort_state", bus.state, S_IDLE);
    check("abort_lrn", bus.layer_rst_n, 3'b000);
    check("abort_busy", busy, 0);
    // stray beats in idle, then a stale layer-1 done
    bus.pix_valid = 1'b1;
    repeat (4) cyc();
    bus.pix_valid = 1'b0;
    stale1 = 1'b1;
    bus.class_in = 4'd9;
    push_st(S_LOAD, 3'b000, 1, -1);
    push_st(S_LAYER_1, 3'b001, 1, 784);
    push_st(S_LAYER_2, 3'b011, 1, 2);
    push_st(S_LAYER_3, 3'b111, 1, 197);
    push_st(S_RESULT, 3'b000, 0, 197);
    push_res(4'd9, 16'd1181);
    do_start();
    run_load(1'b0);
    wait_state(S_LAYER_2, 10);
    stale1 = 1'b0;
    wait_state(S_RESULT, 500);
    check("stale_class", class_out, 9);
    repeat (3) cyc();
    check("st_q_drained", st_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
